cfg_loader: RTL and testbench

Configuration and run sequencer for the PE mesh. It sits directly upstream of the switch array. It accepts configuration entries from the host over a valid/ready stream and buffers them in a FIFO. It then assembles 64-bit routed configuration packets and streams them into the mesh edge on the north or west configuration bus with `load` held high. Once the mesh has drained, it drops `load` and drives the two-phase `edge_trigger` operand sequence for a programmed number of cycles.

---
 rtl/cfg_pkg.sv | 47 ++++
 rtl/cfg_fifo.sv | 53 +++++
 rtl/cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_cfg_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types for the mesh configuration loader: packet field layout,
// the switch consume pattern, the host entry struct and the FSM states.
package cfg_pkg;

    localparam int PKT_W    = 64;
    localparam int HOP_W    = 20;
    localparam int HOP_LSB  = 44;
    localparam int SMP_LSB  = 40;
    localparam int DSG_LSB  = 36;
    localparam int OPC_LSB  = 32;
    localparam int FIELD_W  = 4;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 32;

    // A switch consumes the packet once its hop field shifts to this value.
    localparam logic [HOP_W-1:0] CONSUME = 20'h80000;

    typedef struct packed {
        logic [4:0]         hops;
        logic               west;
        logic [FIELD_W-1:0] sampler;
        logic [FIELD_W-1:0] designator;
        logic [FIELD_W-1:0] opcode;
        logic [DATA_W-1:0]  data;
    } cfg_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN
    } state_t;

    // Pre-shift the hop field right so that `hops` left shifts along the
    // path restore the consume pattern at the target switch.
    function automatic logic [PKT_W-1:0] cfg_pack(cfg_entry_t e);
        logic [PKT_W-1:0] p;
        p = '0;
        p[HOP_LSB +: HOP_W]    = CONSUME >> e.hops;
        p[SMP_LSB +: FIELD_W]  = e.sampler;
        p[DSG_LSB +: FIELD_W]  = e.designator;
        p[OPC_LSB +: FIELD_W]  = e.opcode;
        p[DATA_LSB +: DATA_W]  = e.data;
        return p;
    endfunction

endpackage

// File: rtl/cfg_fifo.sv
// Show-ahead synchronous FIFO of cfg_entry_t with async active-high reset.
// Ports: clk, reset, push/wdata, pop/rdata, full, empty, count.
module cfg_fifo
    import cfg_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  cfg_entry_t wdata,
    input  logic       pop,
    output cfg_entry_t rdata,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    cfg_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Buffers host config entries, streams routed packets into the mesh edge,
// waits for the mesh to drain, then runs the two-phase edge_trigger sequence.
// Ports: clk, reset, s_* host stream, start, o_north_config/o_west_config,
// load, configuration_mux, edge_trigger, busy, done, err.
// Optional: CFG_LOADER_RANGE_CHECK_EN drops entries with hops >= MESH_DIM.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int MESH_DIM   = 8,
    parameter int RUN_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_hops,
    input  logic        s_west,
    input  logic [3:0]  s_sampler,
    input  logic [3:0]  s_designator,
    input  logic [3:0]  s_opcode,
    input  logic [31:0] s_data,
    input  logic        start,
    output logic [63:0] o_north_config,
    output logic [63:0] o_west_config,
    output logic        load,
    output logic        configuration_mux,
    output logic        edge_trigger,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    state_t         state;
    cfg_entry_t     in_e;
    cfg_entry_t     head;
    logic           full;
    logic           empty;
    logic [AW:0]    count;
    logic           handshake;
    logic           in_range;
    logic           push;
    logic           pop;
    logic           last;
    logic [4:0]     dcnt;
    logic [31:0]    rcnt;
    logic [63:0]    pkt;

    assign in_e = '{
        hops:       s_hops,
        west:       s_west,
        sampler:    s_sampler,
        designator: s_designator,
        opcode:     s_opcode,
        data:       s_data
    };

    assign s_ready   = !full && (state == ST_IDLE || state == ST_LOAD);
    assign handshake = s_valid && s_ready;
    assign push      = handshake && in_range;
    assign pop       = !empty &&
                       ((state == ST_IDLE && start) || state == ST_LOAD);
    // The burst ends when this pop takes the final entry and no new one
    // arrives on the same edge to keep it going.
    assign last      = (count == (AW+1)'(1)) && !push;
    assign pkt       = cfg_pack(head);

`ifdef CFG_LOADER_RANGE_CHECK_EN
    assign in_range = (s_hops < 5'(MESH_DIM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else       err <= handshake && !in_range;
    end
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
`endif

    cfg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in_e),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_north_config    <= '0;
            o_west_config     <= '0;
            configuration_mux <= 1'b0;
        end else if (pop) begin
            o_north_config    <= head.west ? '0 : pkt;
            o_west_config     <= head.west ? pkt : '0;
            configuration_mux <= head.west;
        end else begin
            o_north_config    <= '0;
            o_west_config     <= '0;
            configuration_mux <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            load         <= 1'b0;
            edge_trigger <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dcnt         <= '0;
            rcnt         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    edge_trigger <= 1'b0;
                    load         <= pop;
                    if (pop) begin
                        busy  <= 1'b1;
                        dcnt  <= '0;
                        state <= last ? ST_DRAIN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load <= 1'b1;
                    dcnt <= '0;
                    if (last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (dcnt == 5'(MESH_DIM + 1)) begin
                        load         <= 1'b0;
                        edge_trigger <= 1'b0;
                        rcnt         <= '0;
                        state        <= ST_RUN;
                    end else begin
                        load <= 1'b1;
                        dcnt <= dcnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (rcnt == 32'(RUN_CYCLES - 1)) begin
                        edge_trigger <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        edge_trigger <= ~edge_trigger;
                        rcnt         <= rcnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed and randomized checks of cfg_loader against a queue-based model.
// Works with or without CFG_LOADER_RANGE_CHECK_EN defined.
module tb_cfg_loader;

    localparam int DEPTH      = 16;
    localparam int MESH_DIM   = 8;
    localparam int RUN_CYCLES = 64;
`ifdef CFG_LOADER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_hops;
    logic        s_west;
    logic [3:0]  s_sampler;
    logic [3:0]  s_designator;
    logic [3:0]  s_opcode;
    logic [31:0] s_data;
    logic        start;
    logic [63:0] o_north_config;
    logic [63:0] o_west_config;
    logic        load;
    logic        configuration_mux;
    logic        edge_trigger;
    logic        busy;
    logic        done;
    logic        err;

    cfg_loader #(
        .DEPTH(DEPTH), .MESH_DIM(MESH_DIM), .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_hops(s_hops), .s_west(s_west),
        .s_sampler(s_sampler), .s_designator(s_designator),
        .s_opcode(s_opcode), .s_data(s_data),
        .start(start),
        .o_north_config(o_north_config), .o_west_config(o_west_config),
        .load(load), .configuration_mux(configuration_mux),
        .edge_trigger(edge_trigger), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       hops;
        bit       west;
        bit [3:0] smp;
        bit [3:0] dsg;
        bit [3:0] opc;
        bit [31:0] data;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hop field is a single one-hot bit, 2^(19-hops), or empty when the
    // target lies beyond the 20-bit field.
    function automatic logic [63:0] exp_pkt(input ent_t e);
        logic [19:0] hf;
        hf = (e.hops < 20) ? 20'(64'd1 << (19 - e.hops)) : 20'd0;
        return {hf, e.smp, e.dsg, e.opc, e.data};
    endfunction

    function automatic ent_t rand_ent(input int max_hops);
        ent_t e;
        e.hops = $urandom_range(max_hops, 0);
        e.west = 1'($urandom_range(1, 0));
        e.smp  = 4'($urandom);
        e.dsg  = 4'($urandom);
        e.opc  = 4'($urandom);
        e.data = $urandom;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ent_t e);
        s_valid      = 1'b1;
        s_hops       = 5'(e.hops);
        s_west       = e.west;
        s_sampler    = e.smp;
        s_designator = e.dsg;
        s_opcode     = e.opc;
        s_data       = e.data;
    endtask

    task automatic push_entry(input ent_t e);
        logic acc;
        drive(e);
        chk("s_ready_idle", s_ready, q.size() < DEPTH);
        acc = s_ready;
        tick();
        s_valid = 1'b0;
        if (acc) begin
            if (RC && e.hops >= MESH_DIM) begin
                chk("err_reject", err, 1);
            end else begin
                chk("err_accept", err, 0);
                q.push_back(e);
            end
        end
    endtask

    task automatic run_seq(input int extra);
        ent_t e;
        ent_t ne;
        int   idx;
        logic [63:0] p;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            p = exp_pkt(e);
            chk("load_pkt", load, 1);
            chk("busy_pkt", busy, 1);
            chk("done_pkt", done, 0);
            chk("mux", configuration_mux, e.west);
            chk("north", o_north_config, e.west ? 64'd0 : p);
            chk("west", o_west_config, e.west ? p : 64'd0);
            if (idx < extra && q.size() > 0) begin
                ne = rand_ent(MESH_DIM - 1);
                drive(ne);
                chk("s_ready_load", s_ready, 1);
                tick();
                s_valid = 1'b0;
                q.push_back(ne);
            end else begin
                tick();
            end
            idx++;
        end
        for (int i = 0; i < MESH_DIM + 1; i++) begin
            chk("load_drain", load, 1);
            chk("north_drain", o_north_config, 0);
            chk("west_drain", o_west_config, 0);
            chk("ready_drain", s_ready, 0);
            tick();
        end
        for (int j = 0; j < RUN_CYCLES; j++) begin
            chk("load_run", load, 0);
            chk("et_run", edge_trigger, 64'(j % 2));
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            tick();
        end
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("et_end", edge_trigger, 0);
        tick();
        chk("done_clear", done, 0);
    endtask

    task automatic check_start_ignored();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_empty", busy, 0);
            chk("load_empty", load, 0);
            tick();
        end
    endtask

    initial begin
        ent_t e;
        int   n;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_hops  = '0;
        s_west  = 1'b0;
        s_sampler    = '0;
        s_designator = '0;
        s_opcode     = '0;
        s_data       = '0;
        start   = 1'b0;
        #1;
        chk("rst_ready", s_ready, 1);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_north", o_north_config, 0);
        chk("rst_west", o_west_config, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #11;
        reset = 1'b0;
        tick();

        check_start_ignored();

        e = '{hops: 0, west: 0, smp: 0, dsg: 0, opc: 4'h3,
              data: 32'hDEAD_BEEF};
        push_entry(e);
        chk("pkt_const", exp_pkt(q[0]), 64'h8000_0003_DEAD_BEEF);
        run_seq(0);

        foreach (q[i]) q.delete(i);
        for (int h = 0; h < 3; h++) begin
            e = rand_ent(0);
            e.hops = (h == 0) ? 0 : (h == 1) ? 2 : 5;
            e.west = 1'b1;
            push_entry(e);
        end
        run_seq(0);

        for (int i = 0; i < DEPTH; i++) push_entry(rand_ent(MESH_DIM - 1));
        chk("ready_full", s_ready, 0);
        push_entry(rand_ent(MESH_DIM - 1));
        run_seq(4);

        push_entry(rand_ent(MESH_DIM - 1));
        push_entry(rand_ent(MESH_DIM - 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("in_drain", load, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_load", load, 0);
        chk("arst_busy", busy, 0);
        chk("arst_north", o_north_config, 0);
        chk("arst_west", o_west_config, 0);
        chk("arst_et", edge_trigger, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        tick();
        chk("ready_after_rst", s_ready, 1);
        check_start_ignored();

        e = rand_ent(0);
        e.hops = MESH_DIM;
        push_entry(e);
        e = rand_ent(0);
        e.hops = 25;
        push_entry(e);
        push_entry(rand_ent(MESH_DIM - 1));
        chk("err_idle", err, 0);
        chk("model_count", q.size(), RC ? 1 : 3);
        run_seq(0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) push_entry(rand_ent(31));
            if (q.size() > 0) run_seq($urandom_range(2, 0));
            else check_start_ignored();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
